// File: rtl/ibr128_stream_sched.sv
// Block-stream sequencer in front of IBR128_core: accepts one 128-bit block at a time, starts the core,
// waits for cipherReady under a watchdog, and hands the result to a valid/ready sink.
module ibr128_stream_sched #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             abort,
  input  logic             cfg_encrypt,
  input  logic [1:0]       cfg_som,
  input  logic [127:0]     cfg_iv,
  input  logic [63:0]      cfg_key0,
  input  logic [63:0]      cfg_key1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_last,
  output logic             core_enable,
  output logic             core_sa,
  output logic             core_encrypt,
  output logic [1:0]       core_som,
  output logic [127:0]     core_plaintext,
  output logic [127:0]     core_iv,
  output logic             core_fb,
  output logic [63:0]      core_key0,
  output logic [63:0]      core_key1,
  input  logic [127:0]     core_ciphertext,
  input  logic             core_cipherready,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] blk_count
);

  // state | meaning
  // IDLE  | waiting for an input block (in_ready=1)
  // LOAD  | one-cycle SA pulse to the core
  // WAIT  | core running, watchdog counting
  // OUT   | result held until sink handshake
  // ERR   | core hung; only abort leaves
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, OUT, ERR} state_t;

  localparam int WD_W = $clog2(TIMEOUT);

  state_t           state_q;
  logic             first_q;
  logic             fb_q;
  logic             last_q;
  logic [127:0]     data_q;
  logic [WD_W-1:0]  wdog_q;
  logic             enc_q;
  logic [1:0]       som_q;
  logic [127:0]     iv_q;
  logic [63:0]      key0_q;
  logic [63:0]      key1_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [127:0]     out_data_q;
  logic             out_last_q;
  logic             core_enable_q;
  logic             core_sa_q;
  logic             busy_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] blk_count_q;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q       <= IDLE;
      first_q       <= 1'b1;
      fb_q          <= 1'b0;
      last_q        <= 1'b0;
      data_q        <= '0;
      wdog_q        <= '0;
      enc_q         <= 1'b0;
      som_q         <= '0;
      iv_q          <= '0;
      key0_q        <= '0;
      key1_q        <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      core_enable_q <= 1'b0;
      core_sa_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      blk_count_q   <= '0;
    end else if (abort) begin
      // blk_count deliberately survives an abort so software can see how far the message got
      state_q       <= IDLE;
      first_q       <= 1'b1;
      wdog_q        <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      core_enable_q <= 1'b0;
      core_sa_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q        <= in_data;
            last_q        <= in_last;
            fb_q          <= ~first_q;
            if (first_q) begin
              enc_q       <= cfg_encrypt;
              som_q       <= cfg_som;
              iv_q        <= cfg_iv;
              key0_q      <= cfg_key0;
              key1_q      <= cfg_key1;
              blk_count_q <= '0;
            end
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b1;
            core_sa_q     <= 1'b1;
            core_enable_q <= 1'b1;
            state_q       <= LOAD;
          end
        end
        LOAD: begin
          // cipherReady seen here belongs to a previous operation and is ignored
          core_sa_q <= 1'b0;
          first_q   <= 1'b0;
          wdog_q    <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (core_cipherready) begin
            out_data_q    <= core_ciphertext;
            out_last_q    <= last_q;
            out_valid_q   <= 1'b1;
            core_enable_q <= 1'b0;
            state_q       <= OUT;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            core_enable_q <= 1'b0;
            state_q       <= ERR;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (blk_count_q != '1) blk_count_q <= blk_count_q + 1'b1;
            if (out_last_q) first_q <= 1'b1;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_last       = out_last_q;
  assign core_enable    = core_enable_q;
  assign core_sa        = core_sa_q;
  assign core_encrypt   = enc_q;
  assign core_som       = som_q;
  assign core_plaintext = data_q;
  assign core_iv        = iv_q;
  assign core_fb        = fb_q;
  assign core_key0      = key0_q;
  assign core_key1      = key1_q;
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;
  assign blk_count      = blk_count_q;

endmodule
